// File: rtl/gray_pkg.sv
// Shared pixel-format definitions for the gray image pipeline (rgb2gray, gray_packer).
package gray_pkg;

  // Default gray pixel width in bits.
  localparam int unsigned WIDTH_DEFAULT = 8;

  // Default number of pixels packed per output word.
  localparam int unsigned LANES_DEFAULT = 4;

  // One gray pixel at the default width.
  typedef logic [WIDTH_DEFAULT-1:0] gray_t;

endpackage : gray_pkg

// File: rtl/gray_packer_obuf.sv
// Output holding register for gray_packer: keeps one packed word stable until
// the downstream side takes it.
//
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset
//   load_i           a word closes this cycle; capture data_i/keep_i/last_i
//   data_i/keep_i/last_i  the closing word
//   ready_i          downstream accepts the held word
//   valid_o/data_o/keep_o/last_o  registered output word
//   ready_o          upstream may hand over a pixel (combinational from ready_i)
module gray_packer_obuf
  import gray_pkg::*;
#(
  parameter int unsigned width_p = WIDTH_DEFAULT,
  parameter int unsigned lanes_p = LANES_DEFAULT
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       load_i,
  input  logic [width_p*lanes_p-1:0] data_i,
  input  logic [lanes_p-1:0]         keep_i,
  input  logic                       last_i,
  input  logic                       ready_i,
  output logic                       valid_o,
  output logic [width_p*lanes_p-1:0] data_o,
  output logic [lanes_p-1:0]         keep_o,
  output logic                       last_o,
  output logic                       ready_o
);

  localparam int unsigned DATA_W = width_p * lanes_p;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [lanes_p-1:0] keep_q, keep_d;
  logic              last_q,  last_d;

  // Free slot, or the held word leaves on this edge. Held low during reset.
  assign ready_o = !reset_i && (!valid_q || ready_i);

  // Next word: a close always wins, since it is only possible when ready_o=1.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      keep_d  = keep_i;
      last_d  = last_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Output register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign keep_o  = keep_q;
  assign last_o  = last_q;

endmodule : gray_packer_obuf

// File: rtl/gray_packer.sv
// Packs lanes_p gray pixels into one wide word (lane 0 = first pixel = LSBs).
// last_i closes a word early; the partial word carries a lane mask in keep_o.
//
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset
//   gray_i, last_i, valid_i, ready_o   pixel input handshake
//   data_o, keep_o, last_o, valid_o, ready_i   packed word output handshake
module gray_packer
  import gray_pkg::*;
#(
  parameter int unsigned width_p = WIDTH_DEFAULT,
  parameter int unsigned lanes_p = LANES_DEFAULT
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [width_p-1:0]         gray_i,
  input  logic                       last_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  output logic [width_p*lanes_p-1:0] data_o,
  output logic [lanes_p-1:0]         keep_o,
  output logic                       last_o,
  output logic                       valid_o,
  input  logic                       ready_i
);

  localparam int unsigned DATA_W = width_p * lanes_p;
  localparam int unsigned CNT_W  = $clog2(lanes_p);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(lanes_p - 1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  acc_q, acc_d;

  logic               accept_c;
  logic               close_c;
  logic [DATA_W-1:0]  word_c;
  logic [lanes_p-1:0] keep_c;

  assign accept_c = valid_i && ready_o;
  assign close_c  = accept_c && (last_i || (cnt_q == CNT_MAX));

  // Accumulator with the incoming pixel merged into lane cnt; lanes above cnt
  // are already zero because the accumulator clears on every close.
  always_comb begin
    word_c = acc_q;
    keep_c = '0;
    for (int unsigned k = 0; k < lanes_p; k++) begin
      if (CNT_W'(k) == cnt_q) begin
        word_c[k*width_p +: width_p] = gray_i;
      end
      if (CNT_W'(k) <= cnt_q) begin
        keep_c[k] = 1'b1;
      end
    end
  end

  // Lane counter and accumulator update.
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (accept_c) begin
      if (close_c) begin
        cnt_d = '0;
        acc_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        acc_d = word_c;
      end
    end
  end

  // Accumulator state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

  // Output holding register.
  gray_packer_obuf #(
    .width_p (width_p),
    .lanes_p (lanes_p)
  ) u_obuf (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (close_c),
    .data_i  (word_c),
    .keep_i  (keep_c),
    .last_i  (last_i),
    .ready_i (ready_i),
    .valid_o (valid_o),
    .data_o  (data_o),
    .keep_o  (keep_o),
    .last_o  (last_o),
    .ready_o (ready_o)
  );

endmodule : gray_packer

// File: tb/tb_gray_packer.sv
// Self-checking bench for gray_packer (width_p=8, lanes_p=4).
module tb_gray_packer;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [7:0]  gray_i = '0;
  logic        last_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] data_o;
  logic [3:0]  keep_o;
  logic        last_o;
  logic        valid_o;
  logic        ready_i = 1'b0;

  always #5 clk_i = ~clk_i;

  gray_packer dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .gray_i  (gray_i),
    .last_i  (last_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .keep_o  (keep_o),
    .last_o  (last_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  word_t      exp_q[$];
  word_t      obs_q[$];
  logic [7:0] part_q[$];
  word_t      mw;
  word_t      prev_word;
  logic       prev_stall = 1'b0;
  int         stall_viol = 0;
  int         n_in = 0;
  int         n_checks = 0;
  int         n_bad = 0;

  // Reference model and output monitor, both sampled mid-cycle: whatever is
  // visible at the falling edge is what the next rising edge will transfer.
  always @(negedge clk_i) begin
    if (reset_i) begin
      part_q.delete();
    end else begin
      if (valid_i && ready_o) begin
        n_in++;
        part_q.push_back(gray_i);
        if (last_i || part_q.size() == 4) begin
          mw.data = '0;
          for (int k = 0; k < part_q.size(); k++)
            mw.data = mw.data | (32'(part_q[k]) << (8 * k));
          mw.keep = 4'((1 << part_q.size()) - 1);
          mw.last = last_i;
          exp_q.push_back(mw);
          part_q.delete();
        end
      end
      if (valid_o && ready_i) obs_q.push_back({data_o, keep_o, last_o});
      if (prev_stall && (valid_o !== 1'b1 || {data_o, keep_o, last_o} !== prev_word))
        stall_viol++;
    end
    prev_stall = !reset_i && valid_o && !ready_i;
    prev_word  = {data_o, keep_o, last_o};
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Present one pixel and hold it until it is accepted (bounded wait).
  task automatic drive_pixel(input logic [7:0] p, input logic l);
    int  waited = 0;
    bit  done = 0;
    gray_i  = p;
    last_i  = l;
    valid_i = 1'b1;
    while (!done) begin
      @(negedge clk_i);
      if (ready_o) done = 1;
      step();
      if (!done) begin
        waited++;
        if (waited > 50) begin
          n_checks++;
          n_bad++;
          $display("FAIL drive_timeout pixel=%h ready_o stayed low for %0d cycles", p, waited);
          break;
        end
      end
    end
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    ready_i = 1'b1;
    step();
    step();
    @(negedge clk_i);
    n_checks++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", valid_o); end
    n_checks++; if (data_o !== 32'h0) begin n_bad++; $display("FAIL reset_data got=%h want=0", data_o); end
    n_checks++; if (keep_o !== 4'h0) begin n_bad++; $display("FAIL reset_keep got=%h want=0", keep_o); end
    n_checks++; if (last_o !== 1'b0) begin n_bad++; $display("FAIL reset_last got=%b want=0", last_o); end
    n_checks++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_ready got=%b want=0", ready_o); end
    step();
    reset_i = 1'b0;
    step();
  endtask

  task automatic test_full_word();
    ready_i = 1'b1;
    drive_pixel(8'd10, 1'b0);
    drive_pixel(8'd20, 1'b0);
    drive_pixel(8'd30, 1'b0);
    drive_pixel(8'd40, 1'b0);
    @(negedge clk_i);
    n_checks++; if (valid_o !== 1'b1) begin n_bad++; $display("FAIL full_valid got=%b want=1", valid_o); end
    n_checks++; if (data_o !== 32'h281E140A) begin n_bad++; $display("FAIL full_data got=%h want=281e140a", data_o); end
    n_checks++; if (keep_o !== 4'hF) begin n_bad++; $display("FAIL full_keep got=%h want=f", keep_o); end
    n_checks++; if (last_o !== 1'b0) begin n_bad++; $display("FAIL full_last got=%b want=0", last_o); end
    step();
  endtask

  task automatic test_last();
    ready_i = 1'b1;
    drive_pixel(8'd1, 1'b0);
    drive_pixel(8'd2, 1'b0);
    drive_pixel(8'd3, 1'b1);
    @(negedge clk_i);
    n_checks++; if (valid_o !== 1'b1) begin n_bad++; $display("FAIL last3_valid got=%b want=1", valid_o); end
    n_checks++; if (data_o !== 32'h00030201) begin n_bad++; $display("FAIL last3_data got=%h want=00030201", data_o); end
    n_checks++; if (keep_o !== 4'h7) begin n_bad++; $display("FAIL last3_keep got=%h want=7", keep_o); end
    n_checks++; if (last_o !== 1'b1) begin n_bad++; $display("FAIL last3_last got=%b want=1", last_o); end
    step();
    drive_pixel(8'hFF, 1'b1);
    @(negedge clk_i);
    n_checks++; if (data_o !== 32'h000000FF) begin n_bad++; $display("FAIL last1_data got=%h want=000000ff", data_o); end
    n_checks++; if (keep_o !== 4'h1) begin n_bad++; $display("FAIL last1_keep got=%h want=1", keep_o); end
    n_checks++; if (last_o !== 1'b1) begin n_bad++; $display("FAIL last1_last got=%b want=1", last_o); end
    step();
  endtask

  task automatic test_hold();
    ready_i = 1'b0;
    stall_viol = 0;
    drive_pixel(8'hA1, 1'b0);
    drive_pixel(8'hA2, 1'b0);
    drive_pixel(8'hA3, 1'b0);
    drive_pixel(8'hA4, 1'b0);
    obs_q.delete();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      n_checks++;
      if (valid_o !== 1'b1 || data_o !== 32'hA4A3A2A1 || ready_o !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_cycle%0d got valid=%b data=%h ready=%b want 1/a4a3a2a1/0",
                 c, valid_o, data_o, ready_o);
      end
      step();
    end
    ready_i = 1'b1;
    repeat (4) step();
    @(negedge clk_i);
    n_checks++; if (obs_q.size() != 1) begin n_bad++; $display("FAIL hold_release_count got=%0d want=1", obs_q.size()); end
    n_checks++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL hold_release_valid got=%b want=0", valid_o); end
    n_checks++; if (stall_viol != 0) begin n_bad++; $display("FAIL hold_stall_viol got=%0d want=0", stall_viol); end
    step();
  endtask

  task automatic test_back_to_back();
    int          rdy_low = 0;
    int          in0;
    logic [31:0] want;
    obs_q.delete();
    ready_i = 1'b1;
    in0 = n_in;
    valid_i = 1'b1;
    last_i  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      gray_i = 8'(i * 12);
      @(negedge clk_i);
      if (ready_o !== 1'b1) rdy_low++;
      step();
    end
    valid_i = 1'b0;
    repeat (3) step();
    n_checks++; if (rdy_low != 0) begin n_bad++; $display("FAIL b2b_ready_low got=%0d want=0", rdy_low); end
    n_checks++; if (n_in - in0 != 16) begin n_bad++; $display("FAIL b2b_count_in got=%0d want=16", n_in - in0); end
    n_checks++;
    if (obs_q.size() != 4) begin
      n_bad++;
      $display("FAIL b2b_words got=%0d want=4", obs_q.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        want = '0;
        for (int k = 0; k < 4; k++) want = want | (32'(((4 * j + k) * 12) & 255) << (8 * k));
        n_checks++;
        if (obs_q[j] !== {want, 4'hF, 1'b0}) begin
          n_bad++;
          $display("FAIL b2b_word%0d got=%h want=%h", j, obs_q[j], {want, 4'hF, 1'b0});
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_q.delete();
    ready_i = 1'b1;
    drive_pixel(8'h33, 1'b0);
    drive_pixel(8'h44, 1'b0);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    @(negedge clk_i);
    n_checks++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid got=%b want=0", valid_o); end
    step();
    drive_pixel(8'd5, 1'b0);
    drive_pixel(8'd6, 1'b0);
    drive_pixel(8'd7, 1'b0);
    drive_pixel(8'd8, 1'b0);
    @(negedge clk_i);
    n_checks++; if (data_o !== 32'h08070605) begin n_bad++; $display("FAIL rstmid_data got=%h want=08070605", data_o); end
    n_checks++; if (keep_o !== 4'hF) begin n_bad++; $display("FAIL rstmid_keep got=%h want=f", keep_o); end
    step();
    repeat (2) step();
    n_checks++; if (obs_q.size() != 1) begin n_bad++; $display("FAIL rstmid_words got=%0d want=1", obs_q.size()); end
  endtask

  task automatic test_random();
    logic [7:0] pix[200];
    int         idx = 0;
    int         cycles = 0;
    int         n;
    for (int i = 0; i < 200; i++) pix[i] = 8'($urandom);
    obs_q.delete();
    exp_q.delete();
    stall_viol = 0;
    while (idx < 200 && cycles < 20000) begin
      ready_i = ($urandom % 4) != 0;
      valid_i = ($urandom % 4) != 0;
      gray_i  = pix[idx];
      last_i  = (idx == 199) || (($urandom % 6) == 0);
      @(negedge clk_i);
      if (valid_i && ready_o) idx++;
      step();
      cycles++;
    end
    valid_i = 1'b0;
    last_i  = 1'b0;
    ready_i = 1'b1;
    repeat (5) step();
    n_checks++; if (idx != 200) begin n_bad++; $display("FAIL rand_pixels_in got=%0d want=200", idx); end
    n_checks++; if (part_q.size() != 0) begin n_bad++; $display("FAIL rand_partial_left got=%0d want=0", part_q.size()); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rand_word_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    n_checks++; if (stall_viol != 0) begin n_bad++; $display("FAIL rand_stall_viol got=%0d want=0", stall_viol); end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int j = 0; j < n; j++) begin
      n_checks++;
      if (obs_q[j] !== exp_q[j]) begin
        n_bad++;
        $display("FAIL rand_word%0d got=%h want=%h", j, obs_q[j], exp_q[j]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_last();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule : tb_gray_packer
